// File: rtl/product_accumulator.sv
// product_accumulator: sums NUM_TERMS multiplier products captured on prod_done rising edges, valid/ready result
module product_accumulator #(
  parameter int N = 8,
  parameter int NUM_TERMS = 8,
  parameter int GUARD = 3,
  localparam int P_W = 2*N+1,
  localparam int ACC_W = 2*N+1+GUARD,
  localparam int S_W = ACC_W+1,
  localparam int CW = $clog2(NUM_TERMS+1)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic [P_W-1:0]   prod_in,
  input  logic             prod_done,
  input  logic             clr,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [CW-1:0]    term_cnt,
  output logic             ovf,
  output logic             drop_err
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, state_n;
  logic prod_done_q, take, last;
  logic [S_W-1:0] sum;
  logic [CW-1:0] cnt_inc;
  always_comb begin
    take = prod_done & ~prod_done_q;
    sum = {1'b0, acc_out} + S_W'(prod_in);
    cnt_inc = term_cnt + CW'(1);
    last = cnt_inc == CW'(NUM_TERMS);
    state_n = clr ? ACCUM : state == ACCUM ? (take && last ? HOLD : ACCUM) : (acc_ready ? ACCUM : HOLD);
  end
  assign acc_valid = state == HOLD;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ACCUM;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      prod_done_q <= 1'b0;
      acc_out <= '0;
      term_cnt <= '0;
      ovf <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      prod_done_q <= prod_done;
      if (clr) begin
        acc_out <= '0;
        term_cnt <= '0;
        ovf <= 1'b0;
        drop_err <= 1'b0;
      end else if (state == HOLD) begin
        if (take) drop_err <= 1'b1;
        if (acc_ready) begin
          acc_out <= '0;
          term_cnt <= '0;
          ovf <= 1'b0;
        end
      end else if (take) begin
        acc_out <= sum[ACC_W-1:0];
        ovf <= ovf | sum[ACC_W];
        term_cnt <= cnt_inc;
      end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed vector bench for product_accumulator
module tb_product_accumulator;
  logic clk = 0, reset = 0, clr = 0;
  logic [16:0] prod_in = 0;
  logic prod_done = 0, acc_ready = 0, prod_done2 = 0, ready2 = 0;
  logic [19:0] acc_out;
  logic [3:0] term_cnt;
  logic acc_valid, ovf, drop_err;
  logic [16:0] acc_out2;
  logic [1:0] term_cnt2;
  logic acc_valid2, ovf2, drop_err2;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  product_accumulator dut (.clk(clk), .reset(reset), .prod_in(prod_in), .prod_done(prod_done), .clr(clr),
    .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready), .term_cnt(term_cnt), .ovf(ovf), .drop_err(drop_err));
  product_accumulator #(.N(8), .NUM_TERMS(2), .GUARD(0)) dut2 (.clk(clk), .reset(reset), .prod_in(prod_in),
    .prod_done(prod_done2), .clr(clr), .acc_out(acc_out2), .acc_valid(acc_valid2), .acc_ready(ready2),
    .term_cnt(term_cnt2), .ovf(ovf2), .drop_err(drop_err2));
  typedef struct {logic [16:0] prod; logic [19:0] acc; logic [3:0] cnt; logic valid;} vec_t;
  vec_t tbl[16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  task automatic pulse(input logic [16:0] p);
    @(negedge clk); prod_in = p; prod_done = 1;
    @(negedge clk); prod_done = 0;
  endtask
  task automatic pulse2(input logic [16:0] p);
    @(negedge clk); prod_in = p; prod_done2 = 1;
    @(negedge clk); prod_done2 = 0;
  endtask
  task automatic handshake;
    @(negedge clk); acc_ready = 1;
    @(negedge clk); acc_ready = 0;
  endtask
  task automatic do_clr;
    @(negedge clk); clr = 1;
    @(negedge clk); clr = 0;
  endtask
  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{17'd65025, 20'(65025*(i+1)), 4'(i+1), i == 7};
    tbl[8]  = '{17'd100,   20'd100,   4'd1, 1'b0};
    tbl[9]  = '{17'd0,     20'd100,   4'd2, 1'b0};
    tbl[10] = '{17'd65025, 20'd65125, 4'd3, 1'b0};
    tbl[11] = '{17'd3,     20'd65128, 4'd4, 1'b0};
    tbl[12] = '{17'd5,     20'd65133, 4'd5, 1'b0};
    tbl[13] = '{17'd1000,  20'd66133, 4'd6, 1'b0};
    tbl[14] = '{17'd7,     20'd66140, 4'd7, 1'b0};
    tbl[15] = '{17'd1,     20'd66141, 4'd8, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_acc", acc_out, 0); chk("rst_valid", acc_valid, 0); chk("rst_cnt", term_cnt, 0);
    chk("rst_ovf", ovf, 0); chk("rst_drop", drop_err, 0);
    reset = 1;
    for (int i = 0; i < 16; i++) begin
      pulse(tbl[i].prod);
      chk($sformatf("v%0d_acc", i), acc_out, tbl[i].acc);
      chk($sformatf("v%0d_cnt", i), term_cnt, tbl[i].cnt);
      chk($sformatf("v%0d_valid", i), acc_valid, tbl[i].valid);
      if (tbl[i].valid) begin
        chk($sformatf("v%0d_ovf", i), ovf, 0);
        handshake;
        chk("hs_valid", acc_valid, 0); chk("hs_cnt", term_cnt, 0); chk("hs_acc", acc_out, 0);
      end
    end
    @(negedge clk); prod_in = 7; prod_done = 1;
    repeat (20) @(negedge clk);
    chk("lvl_cnt", term_cnt, 1); chk("lvl_acc", acc_out, 7);
    prod_done = 0;
    do_clr;
    chk("clr_cnt", term_cnt, 0); chk("clr_acc", acc_out, 0);
    for (int i = 0; i < 8; i++) pulse(17'd9);
    chk("hold_valid", acc_valid, 1);
    pulse(17'd5);
    chk("drop_err", drop_err, 1); chk("drop_acc", acc_out, 72); chk("drop_cnt", term_cnt, 8);
    handshake;
    chk("drop_hs_cnt", term_cnt, 0); chk("drop_hs_err", drop_err, 1); chk("drop_hs_valid", acc_valid, 0);
    do_clr;
    chk("drop_clr", drop_err, 0);
    for (int i = 0; i < 8; i++) pulse(17'd2);
    @(negedge clk); acc_ready = 1; prod_done = 1; prod_in = 4;
    @(negedge clk); acc_ready = 0; prod_done = 0;
    chk("hs_take_drop", drop_err, 1); chk("hs_take_cnt", term_cnt, 0); chk("hs_take_acc", acc_out, 0);
    do_clr;
    for (int i = 0; i < 3; i++) pulse(17'd10);
    chk("pre_rst_acc", acc_out, 30);
    @(posedge clk); #3 reset = 0; #1;
    chk("arst_acc", acc_out, 0); chk("arst_cnt", term_cnt, 0); chk("arst_valid", acc_valid, 0);
    @(negedge clk); reset = 1;
    for (int i = 0; i < 8; i++) pulse(17'd1);
    chk("post_rst_acc", acc_out, 8); chk("post_rst_valid", acc_valid, 1);
    handshake;
    for (int i = 0; i < 7; i++) pulse(17'd3);
    @(negedge clk); prod_in = 3; prod_done = 1; clr = 1;
    @(negedge clk); prod_done = 0; clr = 0;
    chk("clr8_valid", acc_valid, 0); chk("clr8_cnt", term_cnt, 0); chk("clr8_acc", acc_out, 0);
    chk("clr8_drop", drop_err, 0);
    pulse2(17'h10000);
    chk("g0_cnt1", term_cnt2, 1); chk("g0_valid1", acc_valid2, 0); chk("g0_ovf1", ovf2, 0);
    pulse2(17'h10000);
    chk("g0_acc", acc_out2, 0); chk("g0_ovf", ovf2, 1); chk("g0_valid", acc_valid2, 1);
    @(negedge clk); ready2 = 1;
    @(negedge clk); ready2 = 0;
    chk("g0_hs_ovf", ovf2, 0); chk("g0_hs_valid", acc_valid2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
